ysyx_22050535_seq_ctrl: RTL and testbench
=========================================

Name: ysyx_22050535_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC datapath (PC, IFU, IDU, register file, EXU, EBREAK detect).
- Replaces the free-running one-instruction-per-cycle flow with an explicit FSM.
- Fetch uses a valid/ready request plus a response-valid return, so instruction memory may have variable latency.
- Gates register-file and PC writes to exactly one pulse per retired instruction.
- Halts on ebreak or on a fetch error, and keeps a retired-instruction counter.

Parameters:
ADDR_WIDTH, 32, fetch address width; equals the codebase address width.
INST_WIDTH, 32, instruction width.
CNT_WIDTH, 64, width of the instret counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
run_en  in  1  when 0, FSM holds in FETCH_REQ; does not stall an in-flight instruction
pc  in  ADDR_WIDTH  current PC from the PC register
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  memory accepts request
ifu_req_addr  out  ADDR_WIDTH  fetch address; equals pc
ifu_resp_valid  in  1  instruction returned
ifu_resp_inst  in  INST_WIDTH  returned instruction
ifu_resp_err  in  1  fetch access fault; qualified by ifu_resp_valid
inst_q  out  INST_WIDTH  latched instruction driven to IDU/EXU/EBREAK
is_ebreak  in  1  decoder flag, computed combinationally from inst_q
exu_start  out  1  one-cycle start pulse to EXU
exu_done  in  1  EXU result valid
rf_wen  out  1  register-file write enable, one-cycle pulse
pc_wen  out  1  PC update enable, one-cycle pulse
halted  out  1  sticky; set on ebreak
fault  out  1  sticky; set on fetch error
instret  out  CNT_WIDTH  retired-instruction count
state_o  out  3  current state encoding, for debug

Behaviour:
- State encoding: FETCH_REQ=0, FETCH_WAIT=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6; value 7 is illegal.
- Reset (rst==0 at a clock edge):
  - state=FETCH_REQ, inst_q=0, instret=0, halted=0, fault=0.
  - All pulse outputs are 0.
  - Reset takes effect mid-operation; any outstanding fetch response is dropped.
- FETCH_REQ:
  - ifu_req_valid = run_en.
  - If valid && ready, go to FETCH_WAIT.
  - ifu_req_addr is stable while valid is high.
- FETCH_WAIT:
  - ifu_req_valid=0.
  - On resp_valid && !resp_err: inst_q <= resp_inst, go to DECODE.
  - On resp_valid && resp_err: fault <= 1, go to FAULT.
  - resp_valid in any other state is ignored.
- DECODE: one cycle.
  - If is_ebreak: halted <= 1, instret += 1, go to HALT. No rf_wen, no pc_wen.
  - Otherwise go to EXEC.
- EXEC:
  - exu_start=1 on the first EXEC cycle only.
  - Stay in EXEC until exu_done=1. exu_done is honoured in the same cycle as exu_start.
  - exu_done outside EXEC is ignored.
- WB: one cycle.
  - rf_wen=1 and pc_wen=1 together.
  - instret += 1.
  - Go to FETCH_REQ.
- HALT and FAULT: absorbing states; only reset leaves them. ifu_req_valid=0 and all pulses are 0.
- Illegal state: next state = FAULT and fault is set.
- Latency: minimum 5 cycles per instruction (ready=1, response one cycle after acceptance, exu_done same cycle as start).
- pc is sampled only in FETCH_REQ. The PC register must update only on pc_wen.
- instret wraps modulo 2^CNT_WIDTH; no saturation.
- inst_q holds its value from DECODE through WB and is not cleared between instructions.

Decomposition:
- Shared defines file (existing codebase defines header) gains:
  - state encodings STATE_FETCH_REQ..STATE_FAULT (3 bits);
  - CTRL_STATE_WIDTH=3.
  - It already provides ADDR_WIDTH and INST_WIDTH.
- One natural sub-module: ysyx_22050535_instret_cnt.
  - Inputs: clk, rst, inc.
  - Output: count[CNT_WIDTH-1:0].
  - Synchronous active-low clear, wrap-around.
- The FSM and output decode stay in the top.

Test Plan:
1. Reset, then one addi with ready=1, resp after 1 cycle, exu_done same cycle as start:
   - state sequence is 0,1,2,3,4,0;
   - rf_wen and pc_wen are high only in cycle 5;
   - instret=1.
2. ready low 3 cycles, then high; resp after 4 cycles; exu_done 2 cycles after start:
   - ifu_req_addr stays stable;
   - exu_start is a single pulse;
   - WB occurs at cycle 3+4+1+3+1;
   - exactly one rf_wen.
3. inst_q=0x00100073 (ebreak) returned:
   - halted=1, state=5;
   - rf_wen and pc_wen never assert;
   - instret increments by 1;
   - later resp_valid and exu_done pulses are ignored.
4. resp_valid with resp_err=1:
   - fault=1, state=6, inst_q unchanged, no writes.
   - Then rst=0 for 1 cycle: fault=0, state=0.
5. rst=0 asserted during EXEC:
   - next cycle state=0, instret=0, and no WB pulses.
   - A stray resp_valid arriving after reset is ignored, and no spurious DECODE occurs.
6. Preload instret to 2^64-1 via the sub-module bench, retire one instruction: instret=0.

Source files
------------

// File: rtl/ysyx_22050535_seq_ctrl_pkg.sv
// Shared widths and controller state encoding for the NPC multi-cycle sequencer.
package ysyx_22050535_seq_ctrl_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 32;
   localparam int unsigned DEF_INST_WIDTH   = 32;
   localparam int unsigned DEF_CNT_WIDTH    = 64;
   localparam int unsigned CTRL_STATE_WIDTH = 3;

   // Encoding 7 is deliberately left unused; the FSM treats it as a fault.
   typedef enum logic [CTRL_STATE_WIDTH-1:0] {
      STATE_FETCH_REQ  = 3'd0,
      STATE_FETCH_WAIT = 3'd1,
      STATE_DECODE     = 3'd2,
      STATE_EXEC       = 3'd3,
      STATE_WB         = 3'd4,
      STATE_HALT       = 3'd5,
      STATE_FAULT      = 3'd6
   } ctrl_state_e;

endpackage

// File: rtl/ysyx_22050535_instret_cnt.sv
// Retired-instruction counter: synchronous active-low clear, wraps modulo 2^CNT_WIDTH.
module ysyx_22050535_instret_cnt
   import ysyx_22050535_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/ysyx_22050535_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the NPC datapath.
// Gates RF and PC writes to one pulse per retired instruction; halts on ebreak or fetch fault.
module ysyx_22050535_seq_ctrl
   import ysyx_22050535_seq_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        run_en,
   input  logic [ADDR_WIDTH-1:0]       pc,
   output logic                        ifu_req_valid,
   input  logic                        ifu_req_ready,
   output logic [ADDR_WIDTH-1:0]       ifu_req_addr,
   input  logic                        ifu_resp_valid,
   input  logic [INST_WIDTH-1:0]       ifu_resp_inst,
   input  logic                        ifu_resp_err,
   output logic [INST_WIDTH-1:0]       inst_q,
   input  logic                        is_ebreak,
   output logic                        exu_start,
   input  logic                        exu_done,
   output logic                        rf_wen,
   output logic                        pc_wen,
   output logic                        halted,
   output logic                        fault,
   output logic [CNT_WIDTH-1:0]        instret,
   output logic [CTRL_STATE_WIDTH-1:0] state_o
);

   ctrl_state_e state;
   ctrl_state_e state_next;

   logic exec_seen;
   logic inst_load;
   logic halt_set;
   logic fault_set;
   logic cnt_inc;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= STATE_FETCH_REQ;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         STATE_FETCH_REQ: begin
            if (run_en && ifu_req_ready) begin
               state_next = STATE_FETCH_WAIT;
            end
         end
         STATE_FETCH_WAIT: begin
            if (ifu_resp_valid) begin
               state_next = ifu_resp_err ? STATE_FAULT : STATE_DECODE;
            end
         end
         STATE_DECODE: begin
            state_next = is_ebreak ? STATE_HALT : STATE_EXEC;
         end
         STATE_EXEC: begin
            if (exu_done) begin
               state_next = STATE_WB;
            end
         end
         STATE_WB:    state_next = STATE_FETCH_REQ;
         STATE_HALT:  state_next = STATE_HALT;
         STATE_FAULT: state_next = STATE_FAULT;
         default:     state_next = STATE_FAULT;
      endcase
   end

   // Output and datapath-enable decode
   always_comb begin
      ifu_req_valid = 1'b0;
      exu_start     = 1'b0;
      rf_wen        = 1'b0;
      pc_wen        = 1'b0;
      inst_load     = 1'b0;
      halt_set      = 1'b0;
      fault_set     = 1'b0;
      cnt_inc       = 1'b0;
      case (state)
         STATE_FETCH_REQ: begin
            ifu_req_valid = run_en;
         end
         STATE_FETCH_WAIT: begin
            inst_load = ifu_resp_valid && !ifu_resp_err;
            fault_set = ifu_resp_valid && ifu_resp_err;
         end
         STATE_DECODE: begin
            halt_set = is_ebreak;
            cnt_inc  = is_ebreak;
         end
         STATE_EXEC: begin
            exu_start = !exec_seen;
         end
         STATE_WB: begin
            rf_wen  = 1'b1;
            pc_wen  = 1'b1;
            cnt_inc = 1'b1;
         end
         STATE_HALT, STATE_FAULT: begin
         end
         default: begin
            fault_set = 1'b1;
         end
      endcase
   end

   // exec_seen is low only on the first EXEC cycle, which makes exu_start a single pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_q    <= '0;
         halted    <= 1'b0;
         fault     <= 1'b0;
         exec_seen <= 1'b0;
      end else begin
         if (inst_load) begin
            inst_q <= ifu_resp_inst;
         end
         if (halt_set) begin
            halted <= 1'b1;
         end
         if (fault_set) begin
            fault <= 1'b1;
         end
         exec_seen <= (state == STATE_EXEC);
      end
   end

   assign ifu_req_addr = pc;
   assign state_o      = state;

   ysyx_22050535_instret_cnt #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_instret (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc),
      .count(instret)
   );

endmodule

// File: tb/tb_ysyx_22050535_seq_ctrl.sv
// Self-checking bench for ysyx_22050535_seq_ctrl: vector table, hand corner sequences, random traffic.
module tb_ysyx_22050535_seq_ctrl;

   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam int          KIND_NORM = 0;
   localparam int          KIND_EBRK = 1;
   localparam int          KIND_ERR  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_en;
   logic [31:0] pc;
   logic        ifu_req_ready;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_inst;
   logic        ifu_resp_err;
   logic        exu_done;

   logic        ifu_req_valid, exu_start, rf_wen, pc_wen, halted, fault, is_ebreak;
   logic [31:0] ifu_req_addr, inst_q;
   logic [63:0] instret;
   logic [2:0]  state_o;

   // narrow-counter copy, used to observe instret wrap-around
   logic        req_valid_w, exu_start_w, rf_wen_w, pc_wen_w, halted_w, fault_w, is_ebreak_w;
   logic [31:0] req_addr_w, inst_q_w;
   logic [2:0]  instret_w;
   logic [2:0]  state_w;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] m_instret;
   logic [31:0] m_inst;
   logic        m_halted;
   logic        m_fault;

   always #5 clk = ~clk;

   assign is_ebreak   = (inst_q == EBREAK);
   assign is_ebreak_w = (inst_q_w == EBREAK);

   ysyx_22050535_seq_ctrl dut (
      .clk(clk), .rst(rst), .run_en(run_en), .pc(pc),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_err(ifu_resp_err),
      .inst_q(inst_q), .is_ebreak(is_ebreak), .exu_start(exu_start), .exu_done(exu_done),
      .rf_wen(rf_wen), .pc_wen(pc_wen), .halted(halted), .fault(fault),
      .instret(instret), .state_o(state_o)
   );

   ysyx_22050535_seq_ctrl #(.CNT_WIDTH(3)) dut_w (
      .clk(clk), .rst(rst), .run_en(run_en), .pc(pc),
      .ifu_req_valid(req_valid_w), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(req_addr_w),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_err(ifu_resp_err),
      .inst_q(inst_q_w), .is_ebreak(is_ebreak_w), .exu_start(exu_start_w), .exu_done(exu_done),
      .rf_wen(rf_wen_w), .pc_wen(pc_wen_w), .halted(halted_w), .fault(fault_w),
      .instret(instret_w), .state_o(state_w)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_resp_err   = 1'b0;
      ifu_resp_inst  = $urandom;
      exu_done       = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst    = 1'b0;
      run_en = 1'b1;
      idle_inputs();
      repeat (n) tick();
      rst = 1'b1;
      m_instret = '0;
      m_inst    = '0;
      m_halted  = 1'b0;
      m_fault   = 1'b0;
   endtask

   task automatic check_arch(input string tag);
      check({tag, " instret"}, instret, m_instret);
      check({tag, " instret_w"}, 64'(instret_w), 64'(m_instret[2:0]));
      check({tag, " halted"}, 64'({halted, halted_w}), 64'({m_halted, m_halted}));
      check({tag, " fault"}, 64'({fault, fault_w}), 64'({m_fault, m_fault}));
   endtask

   // One instruction: rw = cycles before ready, hold = cycles with run_en low,
   // rd = response delay after acceptance (>=1), ed = exu_done delay after start.
   task automatic run_instr(input int rw, input int rd, input int ed, input int hold, input int kind,
                            input logic [31:0] inst, input logic [31:0] pcv, input bit noise,
                            output int wb_t);
      int t_acc, t_resp, t_x, t_done, t_end;
      logic [2:0]  es;
      logic [6:0]  ev;
      logic [13:0] obs;
      logic [31:0] eq;
      t_acc  = (hold > rw) ? hold : rw;
      t_resp = t_acc + rd;
      t_x    = t_resp + 2;
      t_done = t_x + ed;
      t_end  = (kind == KIND_NORM) ? t_done + 1 : t_resp + 6;
      wb_t   = -1;
      pc     = pcv;
      for (int t = 0; t <= t_end; t++) begin
         run_en         = (t < hold) ? 1'b0 : (t <= t_acc) ? 1'b1 : 1'($urandom_range(0, 1));
         ifu_req_ready  = (t >= rw);
         ifu_resp_valid = (t == t_resp) ||
                          (noise && (t <= t_acc || t > t_resp) && $urandom_range(0, 2) == 0);
         ifu_resp_err   = (t == t_resp) ? (kind == KIND_ERR) : 1'($urandom_range(0, 1));
         ifu_resp_inst  = (t == t_resp) ? inst : $urandom;
         exu_done       = (kind == KIND_NORM && t == t_done) ||
                          (noise && (kind != KIND_NORM || t < t_x || t > t_done) &&
                           $urandom_range(0, 2) == 0);
         #1;
         if (t <= t_acc)                es = 3'd0;
         else if (t <= t_resp)          es = 3'd1;
         else if (kind == KIND_ERR)     es = 3'd6;
         else if (t == t_resp + 1)      es = 3'd2;
         else if (kind == KIND_EBRK)    es = 3'd5;
         else if (t <= t_done)          es = 3'd3;
         else                           es = 3'd4;
         ev  = {es, (t >= hold && t <= t_acc),
                (kind == KIND_NORM && t == t_x),
                (kind == KIND_NORM && t == t_end), (kind == KIND_NORM && t == t_end)};
         obs = {state_o, ifu_req_valid, exu_start, rf_wen, pc_wen,
                state_w, req_valid_w, exu_start_w, rf_wen_w, pc_wen_w};
         check($sformatf("cycle t=%0d", t), 64'(obs), 64'({ev, ev}));
         if (ifu_req_valid || req_valid_w)
            check($sformatf("req_addr t=%0d", t), {ifu_req_addr, req_addr_w}, {pcv, pcv});
         eq = (t > t_resp && kind != KIND_ERR) ? inst : m_inst;
         if (t == 0 || t > t_resp)
            check($sformatf("inst_q t=%0d", t), {inst_q, inst_q_w}, {eq, eq});
         if (rf_wen && wb_t < 0) wb_t = t;
         tick();
      end
      if (kind == KIND_ERR) begin
         m_fault = 1'b1;
      end else begin
         m_instret = m_instret + 64'd1;
         m_inst    = inst;
         if (kind == KIND_EBRK) m_halted = 1'b1;
      end
      check_arch("post-instr");
   endtask

   typedef struct {
      int          rw;
      int          rd;
      int          ed;
      int          hold;
      logic [31:0] inst;
      logic [31:0] pcv;
      int          exp_wb;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int wb;
      rst = 1'b0;
      run_en = 1'b0;
      pc = 32'h8000_0000;
      idle_inputs();

      vecs[0] = '{0, 1, 0, 0, 32'h0010_0093, 32'h8000_0000, 4};
      vecs[1] = '{3, 4, 2, 0, 32'h0020_8113, 32'h8000_0004, 12};
      vecs[2] = '{1, 2, 5, 0, 32'h0031_0193, 32'h8000_0008, 11};
      vecs[3] = '{0, 1, 1, 3, 32'h0041_8213, 32'h8000_000c, 8};

      // reset values
      do_reset(2);
      #1;
      check("reset state", 64'({state_o, state_w}), 64'(0));
      check("reset inst_q", {inst_q, inst_q_w}, 64'(0));
      check("reset pulses", 64'({exu_start, rf_wen, pc_wen}), 64'(0));
      check_arch("reset");

      // table-driven instruction timings
      foreach (vecs[i]) begin
         run_instr(vecs[i].rw, vecs[i].rd, vecs[i].ed, vecs[i].hold, KIND_NORM,
                   vecs[i].inst, vecs[i].pcv, 1'b0, wb);
         check($sformatf("wb_cycle vec%0d", i), 64'(wb), 64'(vecs[i].exp_wb));
      end
      check("instret after table", instret, 64'd4);

      // reset asserted while in EXEC; stray response afterwards must be ignored
      pc = 32'h8000_0010;
      run_en = 1'b1;
      ifu_req_ready = 1'b1;
      tick();
      ifu_resp_valid = 1'b1;
      ifu_resp_err   = 1'b0;
      ifu_resp_inst  = 32'h0051_0293;
      tick();
      ifu_resp_valid = 1'b0;
      tick();
      #1;
      check("exec entered", 64'({state_o, exu_start}), 64'({3'd3, 1'b1}));
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      run_en = 1'b0;
      ifu_resp_valid = 1'b1;
      ifu_resp_inst  = 32'h0061_8313;
      m_instret = '0;
      m_inst    = '0;
      #1;
      check("rst in exec", 64'({state_o, rf_wen, pc_wen}), 64'(0));
      check("rst in exec instret", instret, 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stray resp k=%0d", k),
               64'({state_o, ifu_req_valid, rf_wen, inst_q}), 64'(0));
      end
      ifu_resp_valid = 1'b0;

      // eight retirements wrap the 3-bit counter back to zero
      for (int n = 0; n < 8; n++) begin
         run_instr($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 4),
                   $urandom_range(0, 2), KIND_NORM, $urandom | 32'h4,
                   32'h8000_0000 + 32'(4 * n), 1'b1, wb);
      end
      check("wrap instret_w", 64'(instret_w), 64'd0);
      check("wrap instret", instret, 64'd8);

      // random traffic
      for (int n = 0; n < 20; n++) begin
         run_instr($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 6),
                   $urandom_range(0, 3), KIND_NORM, $urandom | 32'h4, $urandom & ~32'h3,
                   1'b1, wb);
      end

      // fetch error: fault, absorbing, then one-cycle reset clears it
      run_instr(1, 2, 0, 0, KIND_ERR, 32'h0071_0393, 32'h8000_0100, 1'b1, wb);
      check("fault state", 64'(state_o), 64'd6);
      check("fault no wb", 64'(wb), 64'(-1));
      do_reset(1);
      #1;
      check("fault cleared", 64'({fault, state_o}), 64'(0));
      check("fault rst instret", instret, 64'd0);

      // ebreak halts and counts as retired
      run_instr(0, 1, 2, 0, KIND_NORM, 32'h0081_8413, 32'h8000_0200, 1'b1, wb);
      run_instr(2, 3, 0, 1, KIND_EBRK, EBREAK, 32'h8000_0204, 1'b1, wb);
      check("halt state", 64'({state_o, halted}), 64'({3'd5, 1'b1}));
      check("halt no wb", 64'(wb), 64'(-1));
      check("halt instret", instret, 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
